// File: rtl/trng_key_sched.sv
// Arbitrates N_REQ requesters onto one trng core: warm-up discard, ready timeout,
// idle power-down, one key word per grant. Optional health test: TRNG_SCHED_RCT_EN.
module trng_key_sched #(
    parameter int N_REQ          = 3,
    parameter int N_BITS_KEY     = 32,
    parameter int DISCARD_WORDS  = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int HOLD_CYCLES    = 64,
    parameter int RCT_LIMIT      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_i,
    output logic [N_REQ-1:0]      valid_o,
    output logic [N_BITS_KEY-1:0] key_o,
    output logic                  trng_enable_o,
    output logic                  trng_ack_read_o,
    input  logic                  trng_key_ready_i,
    input  logic [N_BITS_KEY-1:0] trng_key_i,
    output logic                  err_o,
    input  logic                  err_clr_i,
    output logic                  busy_o
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = (DISCARD_WORDS > 0) ? $clog2(DISCARD_WORDS + 1) : 1;

    if (N_REQ < 2 || N_REQ > 8 || RCT_LIMIT < 2) begin : g_param_check
        $error("trng_key_sched: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, WAIT_KEY, ACK, DELIVER} state_t;

    state_t                  state;
    logic [GW-1:0]           grant;
    logic [GW-1:0]           rr_ptr;
    logic [GW-1:0]           arb_idx;
    logic                    arb_hit;
    logic [DW-1:0]           discard_cnt;
    logic [TW-1:0]           timeout_cnt;
    logic [HW-1:0]           hold_cnt;
    logic [N_BITS_KEY-1:0]   word_q;
    logic                    stale_q;
    logic                    enable_q;
    logic                    ack_q;
    logic                    err_q;

`ifdef TRNG_SCHED_RCT_EN
    localparam int RW = $clog2(RCT_LIMIT) + 1;
    logic [N_BITS_KEY-1:0]   prev_word;
    logic [RW-1:0]           rep_cnt;
`endif

    // Round-robin: first requester at or after rr_ptr, wrapping.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!arb_hit && req_i[(32'(rr_ptr) + i) % 32'(N_REQ)]) begin
                arb_hit = 1'b1;
                arb_idx = GW'((32'(rr_ptr) + i) % 32'(N_REQ));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            discard_cnt <= DW'(DISCARD_WORDS);
            timeout_cnt <= '0;
            hold_cnt    <= '0;
            word_q      <= '0;
            stale_q     <= 1'b0;
            enable_q    <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef TRNG_SCHED_RCT_EN
            prev_word   <= '0;
            rep_cnt     <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            // Any error set further down overrides this clear.
            if (err_clr_i) err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!err_q && arb_hit) begin
                        grant       <= arb_idx;
                        hold_cnt    <= '0;
                        timeout_cnt <= '0;
                        stale_q     <= 1'b0;
                        state       <= WAIT_KEY;
                        if (!enable_q) begin
                            enable_q    <= 1'b1;
                            discard_cnt <= DW'(DISCARD_WORDS);
                        end
                    end else if (enable_q) begin
                        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                            enable_q <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                WAIT_KEY: begin
                    stale_q <= 1'b0;
                    if (trng_key_ready_i && !stale_q) begin
                        word_q      <= trng_key_i;
                        timeout_cnt <= '0;
                        ack_q       <= 1'b1;
                        state       <= ACK;
                    end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_q       <= 1'b1;
                        enable_q    <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                ACK: begin
`ifdef TRNG_SCHED_RCT_EN
                    prev_word <= word_q;
`endif
                    if (discard_cnt != '0) begin
                        discard_cnt <= discard_cnt - DW'(1);
                        word_q      <= '0;
                        stale_q     <= 1'b1;
                        state       <= WAIT_KEY;
                    end
`ifdef TRNG_SCHED_RCT_EN
                    else if (word_q == prev_word) begin
                        word_q <= '0;
                        if (rep_cnt == RW'(RCT_LIMIT - 2)) begin
                            err_q    <= 1'b1;
                            enable_q <= 1'b0;
                            rep_cnt  <= '0;
                            state    <= IDLE;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                            stale_q <= 1'b1;
                            state   <= WAIT_KEY;
                        end
                    end else begin
                        rep_cnt <= '0;
                        state   <= DELIVER;
                    end
`else
                    else begin
                        state <= DELIVER;
                    end
`endif
                end
                DELIVER: begin
                    word_q <= '0;
                    rr_ptr <= (grant == GW'(N_REQ - 1)) ? '0 : grant + GW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A withdrawn request suppresses the pulse; the word is dropped on exit.
    always_comb begin
        valid_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            valid_o[i] = (state == DELIVER) && (grant == GW'(i)) && req_i[i];
        end
    end

    assign key_o           = (|valid_o) ? word_q : '0;
    assign trng_enable_o   = enable_q;
    assign trng_ack_read_o = ack_q;
    assign err_o           = err_q;
    assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_trng_key_sched.sv
// Directed bench for trng_key_sched: reactive trng core model plus a delivery scoreboard.
module tb_trng_key_sched;

    localparam int NR   = 3;
    localparam int KW   = 32;
    localparam int TO   = 16;
    localparam int HOLD = 64;
    localparam int DISC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] valid;
    logic [KW-1:0] key;
    logic          en;
    logic          ack;
    logic          key_ready;
    logic [KW-1:0] tkey;
    logic          err;
    logic          err_clr;
    logic          busy;

    always #5 clk = ~clk;

    trng_key_sched #(
        .N_REQ(NR), .N_BITS_KEY(KW), .DISCARD_WORDS(DISC),
        .TIMEOUT_CYCLES(TO), .HOLD_CYCLES(HOLD), .RCT_LIMIT(3)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .valid_o(valid), .key_o(key),
        .trng_enable_o(en), .trng_ack_read_o(ack), .trng_key_ready_i(key_ready),
        .trng_key_i(tkey), .err_o(err), .err_clr_i(err_clr), .busy_o(busy)
    );

    typedef struct {
        int          idx;
        logic [31:0] word;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          ack_cnt = 0;
    bit          prev_ack = 0;
    exp_t        exp_q[$];
    int          got_idx[$];
    logic [31:0] got_key[$];
    logic [31:0] core_q[$];
    bit          stall = 0;
    bit          core_stale = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] w);
        exp_t e;
        e.idx  = idx;
        e.word = w;
        exp_q.push_back(e);
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Core model: presents the queue head while enabled; after an ack the old
    // word stays visible for one more cycle before the next one appears.
    always @(negedge clk) begin
        if (!rst_n || !en) begin
            key_ready  = 1'b0;
            tkey       = '0;
            core_stale = 1'b0;
        end else if (ack) begin
            core_stale = 1'b1;
        end else if (core_stale) begin
            core_stale = 1'b0;
            if (core_q.size() > 0) void'(core_q.pop_front());
        end else begin
            key_ready = !stall && core_q.size() > 0;
            tkey      = key_ready ? core_q[0] : '0;
        end
    end

    // Scoreboard: every delivery must be the next expected (requester, word).
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (valid == '0) begin
                chk("key_zero_when_idle", key, 0);
            end else begin
                exp_t e;
                chk("valid_onehot", $onehot(valid), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_idx", oh_idx(valid), e.idx);
                    chk("deliver_key", key, e.word);
                end
                got_idx.push_back(oh_idx(valid));
                got_key.push_back(key);
            end
            if (ack) begin
                ack_cnt++;
                chk("ack_single_cycle", prev_ack, 0);
            end
            prev_ack = ack;
        end else begin
            prev_ack = 0;
        end
    end

    task automatic wait_valid(input int idx, input int budget, output int cyc);
        int n;
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (valid[idx]) hit = 1;
        end
        chk("valid_within_budget", hit, 1);
        cyc      = n + 1;
        req[idx] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        core_q.delete();
        exp_q.delete();
        stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int cyc;
        int n;
        rst_n   = 1'b0;
        req     = '0;
        err_clr = 1'b0;
        #3;
        chk("rst_valid", valid, 0);
        chk("rst_key", key, 0);
        chk("rst_enable", en, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold start: two discards, third word delivered.
        core_q = '{32'hA, 32'hB, 32'hC};
        push_exp(0, 32'hC);
        got_key.delete();
        a0 = ack_cnt;
        @(negedge clk) req = 3'b001;
        wait_valid(0, 60, cyc);
        chk("cold_ack_count", ack_cnt - a0, 3);
        chk("cold_key", (got_key.size() > 0) ? got_key[0] : 32'h0, 32'hC);

        // All three requesting from rr=0: order 0,1,2.
        do_reset();
        core_q = '{32'hD1, 32'hD2, 32'h11, 32'h22, 32'h33};
        push_exp(0, 32'h11);
        push_exp(1, 32'h22);
        push_exp(2, 32'h33);
        got_idx.delete();
        got_key.delete();
        @(negedge clk) req = 3'b111;
        wait_valid(0, 60, cyc);
        wait_valid(1, 40, cyc);
        wait_valid(2, 40, cyc);
        chk("rr_order_n", got_idx.size(), 3);
        if (got_idx.size() == 3) begin
            chk("rr_order_0", got_key[0], 32'h11);
            chk("rr_order_1", got_key[1], 32'h22);
            chk("rr_order_2", got_key[2], 32'h33);
        end

        // Requester 0 withdraws before delivery; requester 1 gets a fresh word.
        core_q.push_back(32'h44);
        core_q.push_back(32'h55);
        push_exp(1, 32'h55);
        got_key.delete();
        a0 = ack_cnt;
        @(negedge clk) req = 3'b011;
        @(negedge clk) req[0] = 1'b0;
        wait_valid(1, 40, cyc);
        chk("withdraw_ack_count", ack_cnt - a0, 2);
        chk("withdraw_single_delivery", got_key.size(), 1);

        // Timeout with key_ready stuck low.
        stall = 1;
        a0 = ack_cnt;
        @(negedge clk) req = 3'b001;
        @(posedge clk) #1;
        chk("timeout_busy", busy, 1);
        n = 0;
        while (!err && n < 60) begin
            @(posedge clk) #1;
            n++;
        end
        chk("timeout_cycles", n, TO);
        chk("timeout_enable", en, 0);
        chk("timeout_busy_after", busy, 0);
        repeat (5) @(negedge clk);
        chk("err_blocks_grant", busy, 0);
        chk("err_sticky", err, 1);
        chk("timeout_no_ack", ack_cnt - a0, 0);
        core_q = '{32'h61, 32'h62, 32'h63};
        push_exp(0, 32'h63);
        stall = 0;
        a0 = ack_cnt;
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("err_cleared", err, 0);
        wait_valid(0, 60, cyc);
        chk("post_err_ack_count", ack_cnt - a0, 3);

        // Idle hold: enable falls HOLD cycles after entering IDLE.
        @(posedge clk) #1;
        chk("hold_enable_start", en, 1);
        n = 0;
        while (en && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        chk("hold_cycles", n, HOLD);
        core_q = '{32'h71, 32'h72, 32'h73};
        push_exp(1, 32'h73);
        a0 = ack_cnt;
        @(negedge clk) req = 3'b010;
        wait_valid(1, 60, cyc);
        chk("rewarm_ack_count", ack_cnt - a0, 3);

`ifndef TRNG_SCHED_RCT_EN
        // Repeated word is delivered as-is; warm latency is 4 cycles.
        got_key.delete();
        core_q.push_back(32'h5);
        push_exp(2, 32'h5);
        @(negedge clk);
        @(negedge clk) req = 3'b100;
        wait_valid(2, 40, cyc);
        chk("warm_latency_a", cyc, 4);
        core_q.push_back(32'h5);
        push_exp(0, 32'h5);
        @(negedge clk);
        @(negedge clk) req = 3'b001;
        wait_valid(0, 40, cyc);
        chk("warm_latency_b", cyc, 4);
        chk("repeat_word_count", got_key.size(), 2);
`endif

        // Asynchronous reset during the ack pulse.
        core_q.push_back(32'h81);
        @(negedge clk) req = 3'b001;
        n = 0;
        while (!ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ack_before_reset", ack, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ack", ack, 0);
        chk("async_rst_enable", en, 0);
        chk("async_rst_busy", busy, 0);
        req = '0;
        core_q.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("post_rst_enable", en, 0);
        chk("post_rst_err", err, 0);
        chk("all_expected_delivered", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
